// File: rtl/ocp_sram_slave_pkg.sv
// Shared OCP types, slave FSM states and address-decode helpers.
package ocp_sram_slave_pkg;

    typedef enum logic [2:0] {
        CMD_IDLE = 3'd0,
        CMD_WR   = 3'd1,
        CMD_RD   = 3'd2,
        CMD_RDEX = 3'd3,
        CMD_RDL  = 3'd4,
        CMD_WRNP = 3'd5,
        CMD_WRC  = 3'd6,
        CMD_BCST = 3'd7
    } Ocp_cmd;

    typedef enum logic [1:0] {
        RESP_NULL = 2'd0,
        RESP_DVA  = 2'd1,
        RESP_FAIL = 2'd2,
        RESP_ERR  = 2'd3
    } Ocp_resp;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RDWAIT,
        S_RESP
    } Ocp_slave_state;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // True when addr lies in [base, base+span); subtracting first avoids overflow at the top of the map.
    function automatic logic addr_in_range(input logic [63:0] addr,
                                           input logic [63:0] base,
                                           input logic [63:0] span);
        return (addr >= base) && ((addr - base) < span);
    endfunction

endpackage

// File: rtl/ocp_sram_slave_addr_decode.sv
// Combinational window check and byte-address to word-index conversion.
module ocp_addr_decode
    import ocp_sram_slave_pkg::*;
#(
    parameter int              DATA_W    = 32,
    parameter int              DEPTH     = 1024,
    parameter longint unsigned BASE_ADDR = 0,
    parameter int              ADDR_W    = 32
) (
    input  logic [ADDR_W-1:0]       addr,
    output logic                    in_range,
    output logic [clog2(DEPTH)-1:0] index
);

    localparam int          IDX_W   = clog2(DEPTH);
    localparam int          BYTE_SH = clog2(DATA_W / 8);
    localparam logic [63:0] SPAN    = 64'(DEPTH) * 64'(DATA_W / 8);

    // Range is judged on the full offset; truncation to the SRAM index happens afterwards.
    always_comb begin
        in_range = addr_in_range(64'(addr), 64'(BASE_ADDR), SPAN);
        index    = IDX_W'((64'(addr) - 64'(BASE_ADDR)) >> BYTE_SH);
    end

endmodule

// File: rtl/ocp_sram_slave.sv
// OCP slave terminating requests into a single-port SRAM macro.
module ocp_sram_slave
    import ocp_sram_slave_pkg::*;
#(
    parameter int              DATA_W    = 32,
    parameter int              DEPTH     = 1024,
    parameter longint unsigned BASE_ADDR = 0,
    parameter int              ADDR_W    = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [2:0]              mcmd,
    input  logic [ADDR_W-1:0]       maddr,
    input  logic [DATA_W-1:0]       mdata,
    input  logic [DATA_W/8-1:0]     mbyteen,
    output logic                    scmdaccept,
    output logic [1:0]              sresp,
    output logic [DATA_W-1:0]       sdata,
    input  logic                    mrespaccept,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [DATA_W/8-1:0]     mem_be,
    output logic [clog2(DEPTH)-1:0] mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic [DATA_W-1:0]       mem_rdata
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = clog2(DEPTH);

    Ocp_slave_state    state, state_nx;
    logic [1:0]        sresp_nx;
    logic [DATA_W-1:0] sdata_nx;
    logic              en_nx, we_nx;
    logic [BE_W-1:0]   be_nx;
    logic [IDX_W-1:0]  addr_nx;
    logic [DATA_W-1:0] wdata_nx;
    logic              in_range;
    logic [IDX_W-1:0]  index;

    ocp_addr_decode #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE_ADDR),
        .ADDR_W    (ADDR_W)
    ) u_decode (
        .addr     (maddr),
        .in_range (in_range),
        .index    (index)
    );

    // Only one request may be outstanding, so commands are taken only from IDLE.
    assign scmdaccept = (state == S_IDLE) && (mcmd != CMD_IDLE);

    // Next-state and next-output logic; SRAM strobes default low so each access is a single-cycle pulse.
    always_comb begin
        state_nx = state;
        sresp_nx = sresp;
        sdata_nx = sdata;
        en_nx    = 1'b0;
        we_nx    = 1'b0;
        be_nx    = '0;
        addr_nx  = mem_addr;
        wdata_nx = mem_wdata;
        case (state)
            S_IDLE: begin
                if (scmdaccept) begin
                    case (Ocp_cmd'(mcmd))
                        CMD_WR, CMD_BCST: begin
                            if (in_range) begin
                                en_nx    = 1'b1;
                                we_nx    = 1'b1;
                                be_nx    = mbyteen;
                                addr_nx  = index;
                                wdata_nx = mdata;
                            end
                        end
                        CMD_WRNP: begin
                            state_nx = S_RESP;
                            sdata_nx = '0;
                            if (in_range) begin
                                en_nx    = 1'b1;
                                we_nx    = 1'b1;
                                be_nx    = mbyteen;
                                addr_nx  = index;
                                wdata_nx = mdata;
                                sresp_nx = RESP_DVA;
                            end else begin
                                sresp_nx = RESP_ERR;
                            end
                        end
                        CMD_RD: begin
                            if (in_range) begin
                                en_nx    = 1'b1;
                                addr_nx  = index;
                                state_nx = S_RDWAIT;
                            end else begin
                                state_nx = S_RESP;
                                sresp_nx = RESP_ERR;
                                sdata_nx = '0;
                            end
                        end
                        default: begin
                            state_nx = S_RESP;
                            sresp_nx = RESP_ERR;
                            sdata_nx = '0;
                        end
                    endcase
                end
            end
            S_RDWAIT: begin
                sdata_nx = mem_rdata;
                sresp_nx = RESP_DVA;
                state_nx = S_RESP;
            end
            S_RESP: begin
                if (mrespaccept) begin
                    sresp_nx = RESP_NULL;
                    sdata_nx = '0;
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
                sresp_nx = RESP_NULL;
            end
        endcase
    end

    // State, response and SRAM-interface registers; reset drops any pending response at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            sresp     <= RESP_NULL;
            sdata     <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_nx;
            sresp     <= sresp_nx;
            sdata     <= sdata_nx;
            mem_en    <= en_nx;
            mem_we    <= we_nx;
            mem_be    <= be_nx;
            mem_addr  <= addr_nx;
            mem_wdata <= wdata_nx;
        end
    end

endmodule
